fetch_stage: RTL and testbench

Instruction-fetch stage with IF/ID instruction register for the MiniMIPS core. Owns the PC and drives a single-outstanding request/ready instruction-memory interface. Holds the fetched 16-bit word in the instruction register and splits it into fields; `op` feeds the main control decoder directly. Accepts stall and branch-redirect from downstream, and halts on an illegal opcode.

---
 rtl/fetch_stage_if.sv | 71 +++++++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, instruction memory and the downstream decode
// stage. The master side is the fetch stage; the slave side is the memory plus
// downstream logic (or a testbench standing in for them).
//
// Handshake: imem_req/imem_ready is a single-outstanding request/ready pair.
// imem_addr is stable while imem_req is high. A cycle with imem_req && imem_ready
// completes the request and imem_rdata is taken that cycle. branch_taken aborts
// any request in flight; a response in the same cycle is discarded.
interface fetch_stage_if #(
    parameter int PC_W = 16
);
    // instruction memory side
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [15:0]     imem_rdata;

    // downstream control
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;

    // IF/ID register contents
    logic            instr_valid;
    logic [3:0]      op;
    logic [2:0]      rs;
    logic [2:0]      rt;
    logic [2:0]      rd;
    logic [2:0]      funct;
    logic [15:0]     imm_sext;
    logic [PC_W-1:0] pc_plus1;
    logic            halted;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        input  stall,
        input  branch_taken,
        input  branch_target,
        output instr_valid,
        output op,
        output rs,
        output rt,
        output rd,
        output funct,
        output imm_sext,
        output pc_plus1,
        output halted
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        output stall,
        output branch_taken,
        output branch_target,
        input  instr_valid,
        input  op,
        input  rs,
        input  rt,
        input  rd,
        input  funct,
        input  imm_sext,
        input  pc_plus1,
        input  halted
    );
endinterface

// File: rtl/fetch_stage.sv
// MiniMIPS instruction-fetch stage. Owns the PC, issues one outstanding fetch at
// a time, and holds the fetched word in the IF/ID instruction register. Decode
// fields are split combinationally from the IR. An illegal opcode (1010-1111)
// that is actually consumed parks the stage in HALT until reset.
module fetch_stage #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        bus,
    output logic [1:0]           o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_pc_plus1;
    logic [15:0]     r_ir;
    logic            r_valid;
    logic            r_halted;

    logic            w_req;
    logic            w_load;
    logic            w_consume;
    logic            w_illegal;
    logic [PC_W-1:0] w_pc_inc;

    // Request/consume qualifiers. Redirect suppresses both the request and the
    // consume so a flushed word never retires and never halts the stage.
    always_comb begin
        w_req     = (r_state == S_FETCH) && !bus.branch_taken &&
                    (!r_valid || !bus.stall);
        w_load    = w_req && bus.imem_ready;
        w_consume = (r_state == S_FETCH) && r_valid && !bus.stall &&
                    !bus.branch_taken;
        w_illegal = (r_ir[15:12] >= 4'b1010);
        w_pc_inc  = r_pc + PC_W'(1);
    end

    // Control FSM together with PC and IF/ID register update. Priority inside
    // FETCH: redirect, then retiring an illegal opcode, then load, then plain
    // consume. A load that coincides with an illegal retire is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_pc_plus1 <= '0;
            r_ir       <= 16'h0000;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.branch_taken) begin
                        r_pc    <= bus.branch_target;
                        r_valid <= 1'b0;
                    end else if (w_consume && w_illegal) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_valid  <= 1'b0;
                    end else if (w_load) begin
                        r_ir       <= bus.imem_rdata;
                        r_valid    <= 1'b1;
                        r_pc       <= w_pc_inc;
                        r_pc_plus1 <= w_pc_inc;
                    end else if (w_consume) begin
                        r_valid <= 1'b0;
                    end
                end
                S_HALT: begin
                    r_halted <= 1'b1;
                    r_valid  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory request and decode fields straight from the PC and IR.
    always_comb begin
        bus.imem_req    = w_req;
        bus.imem_addr   = r_pc;
        bus.instr_valid = r_valid;
        bus.op          = r_ir[15:12];
        bus.rs          = r_ir[11:9];
        bus.rt          = r_ir[8:6];
        bus.rd          = r_ir[5:3];
        bus.funct       = r_ir[2:0];
        bus.imm_sext    = {{10{r_ir[5]}}, r_ir[5:0]};
        bus.pc_plus1    = r_pc_plus1;
        bus.halted      = r_halted;
        o_state         = r_state;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Memory returns 16'h1000+addr unless a fixed
// word is selected. Each instruction expected to retire is pushed as
// {pc_plus1, ir}; a monitor pops on every consume and compares.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [1:0]  dbg_state;
  logic        use_fixed;
  logic [15:0] fixed_word;

  int n_checks;
  int n_err;

  logic [31:0] exp_q[$];

  fetch_stage_if #(.PC_W(16)) bus ();

  fetch_stage #(
    .PC_W(16),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .o_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imem_rdata = use_fixed ? fixed_word : (16'h1000 + bus.imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: every consumed instruction must match the queue head
  always @(negedge clk) begin
    if (rst_n && bus.instr_valid && !bus.stall && !bus.branch_taken) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got %h%h with no expected entry", bus.pc_plus1, bus.op);
      end else begin
        check("sb_retire",
              {bus.pc_plus1, bus.op, bus.rs, bus.rt, bus.rd, bus.funct},
              exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_err = 0;
    rst_n = 1'b0;
    use_fixed = 1'b0;
    fixed_word = 16'h0000;
    bus.imem_ready = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 16'h0000;

    // reset values
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_req", bus.imem_req, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_pc_plus1", bus.pc_plus1, 0);
    check("rst_addr", bus.imem_addr, 16'h0000);
    check("rst_op", bus.op, 0);

    // sequential fetch, zero-wait memory, then 3 wait states at addr 5
    for (int k = 0; k < 6; k++) exp_q.push_back({16'(k + 1), 16'(16'h1000 + k)});
    next_cycle();
    bus.imem_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req", bus.imem_req, 0);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("seq_req", bus.imem_req, 1);
      check("seq_addr", bus.imem_addr, 32'(k));
      if (k == 0) begin
        check("seq_valid0", bus.instr_valid, 0);
      end else begin
        check("seq_valid", bus.instr_valid, 1);
        check("seq_op", bus.op, 4'h1);
        check("seq_pc_plus1", bus.pc_plus1, 32'(k));
      end
      next_cycle();
    end
    bus.imem_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("wait_addr", bus.imem_addr, 16'h0005);
      check("wait_req", bus.imem_req, 1);
      check("wait_valid", bus.instr_valid, (j == 0) ? 1 : 0);
      next_cycle();
    end
    bus.imem_ready = 1'b1;
    @(negedge clk);
    check("wait_ready_valid", bus.instr_valid, 0);
    check("wait_ready_addr", bus.imem_addr, 16'h0005);
    next_cycle();
    @(negedge clk);
    check("wait_done_valid", bus.instr_valid, 1);
    check("wait_done_funct", bus.funct, 3'd5);
    check("wait_done_pc_plus1", bus.pc_plus1, 16'h0006);
    check("wait_done_addr", bus.imem_addr, 16'h0006);

    // stall with 16'h1234 in the IR
    exp_q.push_back({16'h0007, 16'h1234});
    use_fixed = 1'b1;
    fixed_word = 16'h1234;
    next_cycle();
    bus.stall = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("stall_valid", bus.instr_valid, 1);
      check("stall_rs", bus.rs, 3'd1);
      check("stall_rt", bus.rt, 3'd0);
      check("stall_rd", bus.rd, 3'd6);
      check("stall_imm", bus.imm_sext, 16'hFFF4);
      check("stall_req", bus.imem_req, 0);
      check("stall_pc_plus1", bus.pc_plus1, 16'h0007);
      next_cycle();
    end
    bus.stall = 1'b0;
    use_fixed = 1'b0;
    @(negedge clk);
    check("unstall_req", bus.imem_req, 1);
    check("unstall_addr", bus.imem_addr, 16'h0007);
    next_cycle();

    // redirect with simultaneous response; IR 0x1007 is flushed
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0040;
    @(negedge clk);
    check("br_req", bus.imem_req, 0);
    next_cycle();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    check("br_valid", bus.instr_valid, 0);
    check("br_addr", bus.imem_addr, 16'h0040);
    check("br_req_after", bus.imem_req, 1);
    next_cycle();
    // redirect together with stall; IR 0x1040 is flushed
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0080;
    @(negedge clk);
    check("brst_req", bus.imem_req, 0);
    next_cycle();
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    @(negedge clk);
    check("brst_valid", bus.instr_valid, 0);
    check("brst_addr", bus.imem_addr, 16'h0080);
    exp_q.push_back({16'h0081, 16'h1080});
    next_cycle();
    @(negedge clk);
    check("brst_pc_plus1", bus.pc_plus1, 16'h0081);

    // illegal opcode: first copy is flushed, second copy retires
    use_fixed = 1'b1;
    fixed_word = 16'hA000;
    next_cycle();
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0010;
    @(negedge clk);
    check("ill_op", bus.op, 4'hA);
    check("ill_valid", bus.instr_valid, 1);
    next_cycle();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    check("ill_flush_halted", bus.halted, 0);
    check("ill_flush_valid", bus.instr_valid, 0);
    check("ill_flush_addr", bus.imem_addr, 16'h0010);
    check("ill_flush_req", bus.imem_req, 1);
    exp_q.push_back({16'h0011, 16'hA000});
    next_cycle();
    @(negedge clk);
    check("ill_live_valid", bus.instr_valid, 1);
    next_cycle();
    @(negedge clk);
    check("halt_halted", bus.halted, 1);
    check("halt_valid", bus.instr_valid, 0);
    check("halt_req", bus.imem_req, 0);
    next_cycle();
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0020;
    bus.stall = 1'b1;
    @(negedge clk);
    check("halt_br_halted", bus.halted, 1);
    check("halt_br_req", bus.imem_req, 0);
    next_cycle();
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    @(negedge clk);
    check("halt_hold_halted", bus.halted, 1);
    check("halt_hold_valid", bus.instr_valid, 0);
    check("halt_hold_req", bus.imem_req, 0);

    // reset leaves HALT; redirect to 7 then reset during a wait state
    next_cycle();
    rst_n = 1'b0;
    use_fixed = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2_halted", bus.halted, 0);
    check("rst2_req", bus.imem_req, 0);
    next_cycle();
    @(negedge clk);
    check("rst2_addr", bus.imem_addr, 16'h0000);
    check("rst2_req_fetch", bus.imem_req, 1);
    next_cycle();
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0007;
    bus.imem_ready = 1'b0;
    @(negedge clk);
    check("rst2_pc_plus1", bus.pc_plus1, 16'h0001);
    next_cycle();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    check("mid_addr", bus.imem_addr, 16'h0007);
    check("mid_req", bus.imem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", bus.imem_req, 0);
    check("async_addr", bus.imem_addr, 16'h0000);
    check("async_pc_plus1", bus.pc_plus1, 16'h0000);
    check("async_op", bus.op, 0);
    check("async_valid", bus.instr_valid, 0);
    check("async_halted", bus.halted, 0);
    next_cycle();
    next_cycle();
    bus.imem_ready = 1'b1;
    rst_n = 1'b1;
    exp_q.push_back({16'h0001, 16'h1000});
    @(negedge clk);
    check("rel_idle_req", bus.imem_req, 0);
    next_cycle();
    @(negedge clk);
    check("rel_addr", bus.imem_addr, 16'h0000);
    check("rel_req", bus.imem_req, 1);
    next_cycle();
    bus.imem_ready = 1'b0;
    @(negedge clk);
    check("rel_valid", bus.instr_valid, 1);
    check("rel_pc_plus1", bus.pc_plus1, 16'h0001);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
